// File: rtl/sdram_arbiter.sv
// Three-port slot arbiter in front of an SDRAM controller: one access per clkref period,
// with starvation override for ports 1/2, round-robin between them, and periodic idle slots.
module sdram_arbiter #(
  parameter int unsigned MAX_WAIT         = 4,
  parameter int unsigned REFRESH_INTERVAL = 64
) (
  input  logic        clk,
  input  logic        init,
  input  logic        clkref,
  input  logic [2:0]  req,
  input  logic [2:0]  wr,
  input  logic [68:0] p_addr,
  input  logic [5:0]  p_bank,
  input  logic [23:0] p_din,
  output logic [2:0]  ack,
  output logic [23:0] p_dout,
  output logic [22:0] sd_addr,
  output logic [1:0]  sd_bank,
  output logic [7:0]  sd_din,
  output logic        sd_oe,
  output logic        sd_we,
  input  logic [7:0]  sd_dout,
  output logic [1:0]  grant
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 2);
  localparam int unsigned RW = $clog2(REFRESH_INTERVAL + 2);
  localparam logic [1:0]  GIdle = 2'b11;

  logic          r_ref_d;
  logic [2:0]    r_ack;
  logic [23:0]   r_dout;
  logic [22:0]   r_addr;
  logic [1:0]    r_bank;
  logic [7:0]    r_din;
  logic          r_oe;
  logic          r_we;
  logic [1:0]    r_grant;
  logic [WW-1:0] r_wait1;
  logic [WW-1:0] r_wait2;
  logic          r_rr;      // 0: port 1 preferred, 1: port 2 preferred
  logic [RW-1:0] r_refcnt;

  logic          w_t;
  logic          w_starve1;
  logic          w_starve2;
  logic          w_force_idle;
  logic [1:0]    w_next;
  logic [22:0]   w_sel_addr;
  logic [1:0]    w_sel_bank;
  logic [7:0]    w_sel_din;
  logic          w_sel_wr;
  logic [WW-1:0] w_wait1_d;
  logic [WW-1:0] w_wait2_d;

  always_comb begin
    w_t          = clkref & ~r_ref_d & ~init;
    w_starve1    = req[1] & (r_wait1 == WW'(MAX_WAIT));
    w_starve2    = req[2] & (r_wait2 == WW'(MAX_WAIT));
    w_force_idle = (r_refcnt == RW'(REFRESH_INTERVAL));

    w_next = GIdle;
    if (w_force_idle) begin
      w_next = GIdle;
    end else if (w_starve1 && w_starve2) begin
      w_next = r_rr ? 2'd2 : 2'd1;
    end else if (w_starve1) begin
      w_next = 2'd1;
    end else if (w_starve2) begin
      w_next = 2'd2;
    end else if (req[0]) begin
      w_next = 2'd0;
    end else if (req[1] && req[2]) begin
      w_next = r_rr ? 2'd2 : 2'd1;
    end else if (req[1]) begin
      w_next = 2'd1;
    end else if (req[2]) begin
      w_next = 2'd2;
    end

    w_sel_addr = '0;
    w_sel_bank = '0;
    w_sel_din  = '0;
    w_sel_wr   = 1'b0;
    unique case (w_next)
      2'd0: begin
        w_sel_addr = p_addr[22:0];
        w_sel_bank = p_bank[1:0];
        w_sel_din  = p_din[7:0];
        w_sel_wr   = wr[0];
      end
      2'd1: begin
        w_sel_addr = p_addr[45:23];
        w_sel_bank = p_bank[3:2];
        w_sel_din  = p_din[15:8];
        w_sel_wr   = wr[1];
      end
      2'd2: begin
        w_sel_addr = p_addr[68:46];
        w_sel_bank = p_bank[5:4];
        w_sel_din  = p_din[23:16];
        w_sel_wr   = wr[2];
      end
      default: ;
    endcase

    // Wait counters saturate so a starving port stays starving until served.
    w_wait1_d = '0;
    if (req[1] && (w_next != 2'd1)) begin
      w_wait1_d = (r_wait1 == WW'(MAX_WAIT)) ? r_wait1 : r_wait1 + WW'(1);
    end
    w_wait2_d = '0;
    if (req[2] && (w_next != 2'd2)) begin
      w_wait2_d = (r_wait2 == WW'(MAX_WAIT)) ? r_wait2 : r_wait2 + WW'(1);
    end
  end

  always_ff @(posedge clk) begin
    r_ref_d <= clkref;
    if (init) begin
      r_ack    <= '0;
      r_dout   <= '0;
      r_addr   <= '0;
      r_bank   <= '0;
      r_din    <= '0;
      r_oe     <= 1'b0;
      r_we     <= 1'b0;
      r_grant  <= GIdle;
      r_wait1  <= '0;
      r_wait2  <= '0;
      r_rr     <= 1'b0;
      r_refcnt <= '0;
    end else begin
      r_ack <= '0;
      if (w_t) begin
        // Close out the slot that is ending.
        if (r_grant != GIdle) begin
          r_ack <= 3'b001 << r_grant;
          if (!r_we) begin
            unique case (r_grant)
              2'd0:    r_dout[7:0]   <= sd_dout;
              2'd1:    r_dout[15:8]  <= sd_dout;
              2'd2:    r_dout[23:16] <= sd_dout;
              default: ;
            endcase
          end
        end

        r_grant <= w_next;
        r_wait1 <= w_wait1_d;
        r_wait2 <= w_wait2_d;
        if (w_next != GIdle) begin
          r_addr   <= w_sel_addr;
          r_bank   <= w_sel_bank;
          r_din    <= w_sel_din;
          r_oe     <= ~w_sel_wr;
          r_we     <= w_sel_wr;
          r_refcnt <= r_refcnt + RW'(1);
          if (w_next == 2'd1) r_rr <= 1'b1;
          if (w_next == 2'd2) r_rr <= 1'b0;
        end else begin
          r_oe     <= 1'b0;
          r_we     <= 1'b0;
          r_refcnt <= '0;
        end
      end
    end
  end

  assign ack     = r_ack;
  assign p_dout  = r_dout;
  assign sd_addr = r_addr;
  assign sd_bank = r_bank;
  assign sd_din  = r_din;
  assign sd_oe   = r_oe;
  assign sd_we   = r_we;
  assign grant   = r_grant;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a vector table of single slots plus hand-written
// sequences for reset, starvation and refresh idle slots.
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        init;
  logic        clkref;
  logic [2:0]  req;
  logic [2:0]  wr;
  logic [68:0] p_addr;
  logic [5:0]  p_bank;
  logic [23:0] p_din;
  logic [2:0]  ack;
  logic [23:0] p_dout;
  logic [22:0] sd_addr;
  logic [1:0]  sd_bank;
  logic [7:0]  sd_din;
  logic        sd_oe;
  logic        sd_we;
  logic [7:0]  sd_dout;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_errors = 0;

  sdram_arbiter #(
    .MAX_WAIT        (4),
    .REFRESH_INTERVAL(64)
  ) dut (
    .clk    (clk),
    .init   (init),
    .clkref (clkref),
    .req    (req),
    .wr     (wr),
    .p_addr (p_addr),
    .p_bank (p_bank),
    .p_din  (p_din),
    .ack    (ack),
    .p_dout (p_dout),
    .sd_addr(sd_addr),
    .sd_bank(sd_bank),
    .sd_din (sd_din),
    .sd_oe  (sd_oe),
    .sd_we  (sd_we),
    .sd_dout(sd_dout),
    .grant  (grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  wr;
    logic [7:0]  sdo;
    logic [1:0]  g;
    logic        oe;
    logic        we;
    logic [22:0] a;
    logic [1:0]  b;
    logic [7:0]  d;
    logic [2:0]  ack;
    logic [23:0] pd;
  } vec_t;

  vec_t vecs[8];
  logic [1:0] starve_exp[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise clkref for one cycle: the posedge inside is a slot boundary.
  task automatic t_edge();
    clkref = 1'b1;
    tick();
    clkref = 1'b0;
  endtask

  task automatic idle3();
    repeat (3) tick();
  endtask

  task automatic do_reset();
    init   = 1'b1;
    clkref = 1'b0;
    tick();
    tick();
    init = 1'b0;
    tick();
  endtask

  initial begin
    init    = 1'b1;
    clkref  = 1'b0;
    req     = 3'b000;
    wr      = 3'b000;
    sd_dout = 8'h00;
    p_addr  = {23'h7FFFFF, 23'h0ABCDE, 23'h000123};
    p_bank  = {2'd3, 2'd2, 2'd1};
    p_din   = {8'hC3, 8'h22, 8'h11};

    //            req     wr      sdo    g     oe    we    addr        bk    din    ack     p_dout
    vecs[0] = '{3'b001, 3'b000, 8'h00, 2'd0, 1'b1, 1'b0, 23'h000123, 2'd1, 8'h11, 3'b000, 24'h000000};
    vecs[1] = '{3'b000, 3'b000, 8'h5A, 2'd3, 1'b0, 1'b0, 23'h000123, 2'd1, 8'h11, 3'b001, 24'h00005A};
    vecs[2] = '{3'b100, 3'b100, 8'hEE, 2'd2, 1'b0, 1'b1, 23'h7FFFFF, 2'd3, 8'hC3, 3'b000, 24'h00005A};
    vecs[3] = '{3'b000, 3'b000, 8'h77, 2'd3, 1'b0, 1'b0, 23'h7FFFFF, 2'd3, 8'hC3, 3'b100, 24'h00005A};
    vecs[4] = '{3'b110, 3'b000, 8'h00, 2'd1, 1'b1, 1'b0, 23'h0ABCDE, 2'd2, 8'h22, 3'b000, 24'h00005A};
    vecs[5] = '{3'b110, 3'b000, 8'h99, 2'd2, 1'b1, 1'b0, 23'h7FFFFF, 2'd3, 8'hC3, 3'b010, 24'h00995A};
    vecs[6] = '{3'b110, 3'b000, 8'h44, 2'd1, 1'b1, 1'b0, 23'h0ABCDE, 2'd2, 8'h22, 3'b100, 24'h44995A};
    vecs[7] = '{3'b000, 3'b000, 8'h01, 2'd3, 1'b0, 1'b0, 23'h0ABCDE, 2'd2, 8'h22, 3'b010, 24'h44015A};

    starve_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};

    // Reset state
    do_reset();
    chk("rst_grant", 32'(grant), 32'd3);
    chk("rst_oe", 32'(sd_oe), 32'd0);
    chk("rst_we", 32'(sd_we), 32'd0);
    chk("rst_addr", 32'(sd_addr), 32'd0);
    chk("rst_bank", 32'(sd_bank), 32'd0);
    chk("rst_din", 32'(sd_din), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_pdout", 32'(p_dout), 32'd0);

    // Single-slot vectors
    for (int i = 0; i < 8; i++) begin
      req     = vecs[i].req;
      wr      = vecs[i].wr;
      sd_dout = vecs[i].sdo;
      t_edge();
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].g));
      chk($sformatf("v%0d_oe", i), 32'(sd_oe), 32'(vecs[i].oe));
      chk($sformatf("v%0d_we", i), 32'(sd_we), 32'(vecs[i].we));
      chk($sformatf("v%0d_addr", i), 32'(sd_addr), 32'(vecs[i].a));
      chk($sformatf("v%0d_bank", i), 32'(sd_bank), 32'(vecs[i].b));
      chk($sformatf("v%0d_din", i), 32'(sd_din), 32'(vecs[i].d));
      chk($sformatf("v%0d_ack", i), 32'(ack), 32'(vecs[i].ack));
      chk($sformatf("v%0d_pdout", i), 32'(p_dout), 32'(vecs[i].pd));
      tick();
      chk($sformatf("v%0d_ack_pulse", i), 32'(ack), 32'd0);
      chk($sformatf("v%0d_grant_hold", i), 32'(grant), 32'(vecs[i].g));
      tick();
      tick();
    end

    // Reset mid-slot during a port 1 read, with clkref rising while init is high
    req = 3'b010;
    wr  = 3'b000;
    t_edge();
    chk("mid_grant1", 32'(grant), 32'd1);
    chk("mid_oe1", 32'(sd_oe), 32'd1);
    tick();
    init   = 1'b1;
    clkref = 1'b1;
    tick();
    chk("mid_rst_oe", 32'(sd_oe), 32'd0);
    chk("mid_rst_grant", 32'(grant), 32'd3);
    chk("mid_rst_pdout", 32'(p_dout), 32'h0);
    init = 1'b0;
    tick();
    chk("no_t_after_init", 32'(grant), 32'd3);
    chk("no_ack_abandon", 32'(ack), 32'd0);
    clkref = 1'b0;
    tick();
    tick();
    t_edge();
    chk("post_rst_grant", 32'(grant), 32'd1);
    chk("post_rst_ack", 32'(ack), 32'd0);
    chk("post_rst_addr", 32'(sd_addr), 32'h0ABCDE);
    idle3();

    // Starvation with all three ports requesting
    do_reset();
    req = 3'b111;
    wr  = 3'b000;
    for (int i = 0; i < 11; i++) begin
      t_edge();
      chk($sformatf("starve_%0d", i), 32'(grant), 32'(starve_exp[i]));
      idle3();
    end

    // Forced idle slot after 64 consecutive grants
    do_reset();
    req = 3'b001;
    wr  = 3'b000;
    for (int i = 0; i < 66; i++) begin
      t_edge();
      chk($sformatf("refresh_%0d", i), 32'(grant), (i == 64) ? 32'd3 : 32'd0);
      if (i == 64) begin
        chk("refresh_oe", 32'(sd_oe), 32'd0);
        chk("refresh_we", 32'(sd_we), 32'd0);
      end
      idle3();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
